// File: rtl/zstd_pkg.sv
// Shared Zstandard frame-header constants and sizing helpers.
// Used by both the header writer and the header parser.
package zstd_pkg;

  localparam logic [31:0] ZSTD_MAGIC = 32'hFD2FB528;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  function automatic logic [2:0] did_bytes(
    input logic [1:0] flag
  );
    unique case (flag)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] fcs_bytes(
    input logic [1:0] flag,
    input logic       ss
  );
    unique case (flag)
      2'd0:    return ss ? 4'd1 : 4'd0;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/frame_header_writer_if.sv
// Output beat stream of the frame header writer.
// Two byte lanes with per-lane valid and a ready back-pressure.
interface frame_header_writer_if;
  logic [15:0] data_out;
  logic [1:0]  out_valid;
  logic        out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/zstd_header_len.sv
// Frame-header field sizing: DID/FCS byte counts and total length.
// Purely combinational so writer and parser share one definition.
module zstd_header_len
  import zstd_pkg::*;
(
  input  logic       single_segment,
  input  logic [1:0] dict_id_flag,
  input  logic [1:0] fcs_flag,
  output logic [2:0] did_n,
  output logic [3:0] fcs_n,
  output logic [4:0] header_len
);

  always_comb begin
    did_n      = did_bytes(dict_id_flag);
    fcs_n      = fcs_bytes(fcs_flag, single_segment);
    header_len = 5'd5
               + {4'b0, ~single_segment}
               + {2'b0, did_n}
               + {1'b0, fcs_n};
  end

endmodule

// File: rtl/frame_header_writer.sv
// Zstandard frame header writer: captures config on start and
// streams the assembled header two bytes per beat.
module frame_header_writer
  import zstd_pkg::*;
#(
  parameter logic [31:0] MAGIC = ZSTD_MAGIC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        single_segment,
  input  logic        content_checksum,
  input  logic [1:0]  dict_id_flag,
  input  logic [1:0]  fcs_flag,
  input  logic [7:0]  window_descriptor,
  input  logic [31:0] dictionary_id,
  input  logic [63:0] frame_content_size,
  frame_header_writer_if.master out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  header_len
);

  state_t           state_q, state_d;
  logic [17:0][7:0] buf_q, buf_d;
  logic [4:0]       ptr_q, ptr_d;
  logic [4:0]       len_q, len_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       did_n;
  logic [3:0]       fcs_n;
  logic [4:0]       hlen;
  logic [17:0][7:0] hdr;
  logic [63:0]      fcs_val;
  logic [4:0]       pos;
  logic [4:0]       nxt;
  logic             fire;

  zstd_header_len u_len (
    .single_segment (single_segment),
    .dict_id_flag   (dict_id_flag),
    .fcs_flag       (fcs_flag),
    .did_n          (did_n),
    .fcs_n          (fcs_n),
    .header_len     (hlen)
  );

  // Header image built from the live inputs; only latched on start.
  always_comb begin
    hdr    = '0;
    hdr[0] = MAGIC[7:0];
    hdr[1] = MAGIC[15:8];
    hdr[2] = MAGIC[23:16];
    hdr[3] = MAGIC[31:24];
    hdr[4] = {fcs_flag, single_segment, 2'b00,
              content_checksum, dict_id_flag};
    fcs_val = frame_content_size;
    if (fcs_flag == 2'd1)
      fcs_val = {48'b0, frame_content_size[15:0] - 16'd256};
    pos = 5'd5;
    if (!single_segment) begin
      hdr[5] = window_descriptor;
      pos    = 5'd6;
    end
    for (int i = 0; i < 4; i++)
      if (i < int'(did_n))
        hdr[pos + 5'(i)] = dictionary_id[8*i +: 8];
    pos = pos + {2'b0, did_n};
    for (int i = 0; i < 8; i++)
      if (i < int'(fcs_n))
        hdr[pos + 5'(i)] = fcs_val[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fire    = (valid_q != 2'b00) && out.out_ready;
    nxt     = ptr_q + 5'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          buf_d   = hdr;
          len_d   = hlen;
          data_d  = {hdr[1], hdr[0]};
          valid_d = 2'b11;
          ptr_d   = 5'd2;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (fire) begin
          if (ptr_q >= len_q) begin
            state_d = DONE;
            data_d  = '0;
            valid_d = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d[7:0]  = buf_q[ptr_q];
            data_d[15:8] = (nxt < len_q) ? buf_q[nxt] : 8'h00;
            valid_d      = (nxt < len_q) ? 2'b11 : 2'b01;
            ptr_d        = ptr_q + 5'd2;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out.data_out  = data_q;
  assign out.out_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign header_len    = len_q;

endmodule

// File: tb/tb_frame_header_writer.sv
// Bench for frame_header_writer: directed and random frames
// checked against a byte-list model of the header format.
module tb_frame_header_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ss;
  logic        cc;
  logic [1:0]  didf;
  logic [1:0]  fcsf;
  logic [7:0]  wd;
  logic [31:0] id;
  logic [63:0] fv;
  logic        busy;
  logic        done;
  logic [4:0]  hlen;

  int passed = 0;
  int total  = 0;

  typedef logic [7:0] bq_t[$];

  frame_header_writer_if ifc ();

  frame_header_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .single_segment     (ss),
    .content_checksum   (cc),
    .dict_id_flag       (didf),
    .fcs_flag           (fcsf),
    .window_descriptor  (wd),
    .dictionary_id      (id),
    .frame_content_size (fv),
    .out                (ifc),
    .busy               (busy),
    .done               (done),
    .header_len         (hlen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Header as a flat list of stream bytes, straight from the format rules.
  function automatic void model(
    input logic s, input logic c,
    input logic [1:0] df, input logic [1:0] ff,
    input logic [7:0] w, input logic [31:0] d,
    input logic [63:0] f, output bq_t q);
    int dn;
    int fn;
    logic [63:0] fval;
    logic [31:0] mg;
    mg = 32'hFD2FB528;
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(8'(mg >> (8*i)));
    q.push_back({ff, s, 2'b00, c, df});
    if (!s) q.push_back(w);
    dn = (df == 2'd3) ? 4 : int'(df);
    case (ff)
      2'd0:    fn = s ? 1 : 0;
      2'd1:    fn = 2;
      2'd2:    fn = 4;
      default: fn = 8;
    endcase
    fval = (ff == 2'd1) ? (f - 64'd256) : f;
    for (int i = 0; i < dn; i++) q.push_back(8'(d >> (8*i)));
    for (int i = 0; i < fn; i++) q.push_back(8'(fval >> (8*i)));
  endfunction

  task automatic run_frame(
    input logic s, input logic c,
    input logic [1:0] df, input logic [1:0] ff,
    input logic [7:0] w, input logic [31:0] d,
    input logic [63:0] f, input int mode,
    input bit poke, input string nm);
    bq_t q;
    int beats, k, budget, n;
    logic [15:0] pd, ed;
    logic [1:0] pv, ev;
    bit stalled;
    logic r;
    model(s, c, df, ff, w, d, f, q);
    n = q.size();
    ss = s; cc = c; didf = df; fcsf = ff;
    wd = w; id = d; fv = f;
    start = 1'b1;
    ifc.out_ready = 1'b0;
    tick;
    start = 1'b0;
    ss = 1'($urandom); cc = 1'($urandom);
    didf = 2'($urandom); fcsf = 2'($urandom);
    wd = 8'($urandom); id = $urandom;
    fv = {$urandom, $urandom};
    chk({nm, " len"}, 64'(hlen), 64'(n));
    chk({nm, " busy"}, 64'(busy), 64'd1);
    beats = (n + 1) / 2;
    k = 0; budget = 0; stalled = 0;
    pd = '0; pv = '0;
    while (k < beats && budget < 200) begin
      if (stalled) begin
        chk({nm, " hold data"}, 64'(ifc.data_out), 64'(pd));
        chk({nm, " hold valid"}, 64'(ifc.out_valid), 64'(pv));
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (budget % 2 == 0);
      else r = 1'($urandom_range(0, 1));
      if (poke) start = 1'($urandom);
      ifc.out_ready = r;
      pd = ifc.data_out;
      pv = ifc.out_valid;
      if (r) begin
        ed[7:0] = q[2*k];
        if (2*k + 1 < n) begin
          ed[15:8] = q[2*k+1];
          ev = 2'b11;
        end else begin
          ed[15:8] = 8'h00;
          ev = 2'b01;
        end
        chk($sformatf("%s beat%0d data", nm, k),
            64'(ifc.data_out), 64'(ed));
        chk($sformatf("%s beat%0d valid", nm, k),
            64'(ifc.out_valid), 64'(ev));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      tick;
      budget++;
    end
    if (k < beats) chk({nm, " beat budget"}, 64'(k), 64'(beats));
    start = 1'b0;
    ifc.out_ready = 1'($urandom);
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " done valid"}, 64'(ifc.out_valid), 64'd0);
    chk({nm, " done busy"}, 64'(busy), 64'd0);
    tick;
    chk({nm, " done drop"}, 64'(done), 64'd0);
    chk({nm, " idle valid"}, 64'(ifc.out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    ss = 0; cc = 0; didf = 0; fcsf = 0;
    wd = 0; id = 0; fv = 0;
    ifc.out_ready = 1'b0;
    tick;
    tick;
    chk("rst valid", 64'(ifc.out_valid), 64'd0);
    chk("rst data", 64'(ifc.data_out), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst len", 64'(hlen), 64'd0);

    start = 1'b1;
    tick;
    chk("rst prio valid", 64'(ifc.out_valid), 64'd0);
    chk("rst prio busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    tick;

    run_frame(1, 0, 2'd0, 2'd0, 8'h00, 32'h0,
              64'h42, 0, 0, "ss_fcs1");
    run_frame(0, 0, 2'd1, 2'd0, 8'h58, 32'h07,
              64'h0, 0, 0, "wd_did1");
    run_frame(1, 0, 2'd0, 2'd1, 8'h00, 32'h0,
              64'h0300, 0, 0, "fcs2_bias");
    run_frame(0, 1, 2'd3, 2'd3, 8'h3C, 32'hAABBCCDD,
              64'h0102030405060708, 1, 0, "full_toggle");
    run_frame(0, 0, 2'd3, 2'd3, 8'h11, 32'hAABBCCDD,
              64'h0102030405060708, 0, 1, "start_poke");
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("poke extra done", 64'(done), 64'd0);
    end

    ss = 0; cc = 0; didf = 2'd3; fcsf = 2'd3;
    wd = 8'h22; id = 32'hAABBCCDD; fv = 64'h0102030405060708;
    start = 1'b1;
    tick;
    start = 1'b0;
    ifc.out_ready = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort valid", 64'(ifc.out_valid), 64'd0);
    chk("abort data", 64'(ifc.data_out), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort len", 64'(hlen), 64'd0);
    tick;
    chk("abort stays idle", 64'(ifc.out_valid), 64'd0);
    run_frame(0, 0, 2'd3, 2'd3, 8'h22, 32'hAABBCCDD,
              64'h0102030405060708, 0, 0, "after_abort");

    for (int i = 0; i < 25; i++) begin
      run_frame(1'($urandom), 1'($urandom),
                2'($urandom), 2'($urandom),
                8'($urandom), $urandom,
                {$urandom, $urandom}, 2,
                1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
